// File: rtl/bram_fifo_pkg.sv
// Shared definitions for the BRAM-backed stream FIFO controller.
//   OBUF_DEPTH  : entries in the output (read-latency hiding) buffer
//   gnt_t       : which operation owns the single BRAM port this cycle
//   count_width : width of the total-occupancy counter (holds 0..DEPTH+2)
package bram_fifo_pkg;

  localparam int unsigned OBUF_DEPTH = 2;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_WR,
    GNT_RD
  } gnt_t;

  function automatic int unsigned count_width(input int unsigned addr_width);
    return addr_width + 2;
  endfunction

endpackage

// File: rtl/bram.sv
// Single-port block RAM, 1-cycle synchronous read (read-before-write).
//   clk  : clock
//   we   : write enable, writes din to mem[addr]
//   addr : word address
//   din  : write data
//   dout : mem[addr] as sampled on the previous rising edge
module bram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/bram_fifo_obuf.sv
// Two-entry output FIFO that holds words already read out of the BRAM.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : capture a word (caller guarantees room)
//   pop        : remove the head word (ignored when empty)
//   dout       : head word; keeps its last value once the buffer empties
//   valid      : buffer holds at least one word
//   count      : number of words held (0..2)
module bram_fifo_obuf import bram_fifo_pkg::*; #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid,
  output logic [1:0]            count
);

  localparam logic [1:0] FULL = 2'(OBUF_DEPTH);

  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic                  pop_ok;

  always_comb begin
    valid  = (count != 2'd0);
    pop_ok = pop && valid;
    dout   = head;
  end

  // head only shifts when a second word is actually behind it, so the
  // output stays stable after the last word leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      unique case ({push, pop_ok})
        2'b10: begin
          if (count == 2'd0) begin
            head <= din;
          end else begin
            tail <= din;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == FULL) begin
            head <= tail;
          end
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == FULL) begin
            head <= tail;
            tail <= din;
          end else begin
            head <= din;
          end
        end
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop_ok && (count == FULL)));

  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    (count <= FULL));

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Stream FIFO controller in front of a single-port, 1-cycle-latency BRAM.
// Writes and prefetch reads share the one BRAM port; a 2-entry output
// buffer hides the read latency so the read side can sustain 1 word/cycle.
//   clk, rst_n        : clock, asynchronous active-low reset
//   s_valid/s_ready/s_data : write stream
//   m_valid/m_ready/m_data : read stream
//   count             : words held (BRAM + read in flight + output buffer)
//   bram_we/addr/din  : BRAM port drive
//   bram_dout         : BRAM read data, valid the cycle after the read
module bram_fifo_ctrl import bram_fifo_pkg::*; #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [DATA_WIDTH-1:0]                s_data,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [DATA_WIDTH-1:0]                m_data,
  output logic [count_width(ADDR_WIDTH)-1:0]   count,
  output logic                                 bram_we,
  output logic [ADDR_WIDTH-1:0]                bram_addr,
  output logic [DATA_WIDTH-1:0]                bram_din,
  input  logic [DATA_WIDTH-1:0]                bram_dout
);

  localparam int unsigned         CW    = count_width(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   mem_count;
  logic                  rd_pend;
  logic [1:0]            obuf_count;

  logic                  pop;
  logic [1:0]            inflight;
  logic                  rd_elig;
  logic                  starve;
  gnt_t                  gnt;

  // Words already committed to the output side (buffered or in flight);
  // at most 3, and pop implies at least one is buffered, so no underflow.
  always_comb begin
    pop      = m_valid && m_ready;
    inflight = obuf_count + {1'b0, rd_pend};
    rd_elig  = (mem_count != '0) && ((inflight - {1'b0, pop}) < 2'd2);
    // An empty output side with data in the BRAM lets the read beat the
    // writer for one cycle so the consumer is never starved.
    starve   = rd_elig && (inflight == 2'd0);
    s_ready  = (mem_count < DEPTH) && !starve;

    gnt = GNT_IDLE;
    if (s_valid && s_ready) begin
      gnt = GNT_WR;
    end else if (rd_elig) begin
      gnt = GNT_RD;
    end

    bram_we   = (gnt == GNT_WR);
    bram_addr = (gnt == GNT_WR) ? wr_ptr : rd_ptr;
    bram_din  = s_data;

    count = CW'(mem_count) + CW'(rd_pend) + CW'(obuf_count);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      rd_pend   <= 1'b0;
    end else begin
      unique case (gnt)
        GNT_WR: begin
          wr_ptr    <= wr_ptr + 1'b1;
          mem_count <= mem_count + 1'b1;
        end
        GNT_RD: begin
          rd_ptr    <= rd_ptr + 1'b1;
          mem_count <= mem_count - 1'b1;
        end
        default: ;
      endcase
      rd_pend <= (gnt == GNT_RD);
    end
  end

  // The BRAM word read last cycle is captured whenever a read is pending.
  bram_fifo_obuf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_obuf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_pend),
    .din   (bram_dout),
    .pop   (pop),
    .dout  (m_data),
    .valid (m_valid),
    .count (obuf_count)
  );

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
module tb_bram_fifo_ctrl;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = AW + 2;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data  = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [CW-1:0] count;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] bram_dout;

  int checks   = 0;
  int failures = 0;

  // Reference model: FIFO of accepted words, plus a log of words the DUT emitted.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] popped[$];
  int unsigned   wr_total   = 0;
  int            starve_run = 0;
  logic          prev_hold  = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  always #5 clk = ~clk;

  bram_fifo_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .count     (count),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .bram_dout (bram_dout)
  );

  bram #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) u_mem (
    .clk  (clk),
    .we   (bram_we),
    .addr (bram_addr),
    .din  (bram_din),
    .dout (bram_dout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the queue model; transfers commit at the next posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_bram_we", 64'(bram_we), 64'd0);
      exp_q.delete();
      wr_total   = 0;
      starve_run = 0;
      prev_hold  = 1'b0;
    end else begin
      chk("count", 64'(count), 64'(exp_q.size()));
      chk("m_valid_implies_data", 64'(!m_valid || exp_q.size() != 0), 64'd1);
      if (m_valid && exp_q.size() != 0) chk("m_data", 64'(m_data), 64'(exp_q[0]));
      chk("we_is_write_handshake", 64'(bram_we), 64'(s_valid && s_ready));
      if (bram_we) begin
        chk("bram_din", 64'(bram_din), 64'(s_data));
        chk("bram_addr_wr", 64'(bram_addr), 64'(wr_total % DEPTH));
      end
      chk("s_ready_only_low_when_full_or_starved",
          64'(s_ready || exp_q.size() >= DEPTH || !m_valid), 64'd1);
      chk("full_refuses", 64'(!(s_ready && exp_q.size() >= DEPTH + 2)), 64'd1);
      if (exp_q.size() != 0 && !m_valid) starve_run++;
      else starve_run = 0;
      chk("read_latency", 64'(starve_run <= 2), 64'd1);
      if (prev_hold) begin
        chk("hold_valid", 64'(m_valid), 64'd1);
        chk("hold_data", 64'(m_data), 64'(prev_data));
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      if (m_valid && m_ready) begin
        popped.push_back(m_data);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (s_valid && s_ready) begin
        exp_q.push_back(s_data);
        wr_total++;
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input int budget);
    bit done = 0;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (s_ready) done = 1;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    chk("send_accepted", 64'(done), 64'd1);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && count != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_count", 64'(count), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] sent[$];
    logic          acc;
    int            nsent;

    // Reset, then idle.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_m_valid", 64'(m_valid), 64'd0);
      chk("idle_s_ready", 64'(s_ready), 64'd1);
      chk("idle_count", 64'(count), 64'd0);
      chk("idle_bram_we", 64'(bram_we), 64'd0);
    end
    @(posedge clk); #1;

    // Three words with a ready consumer; 3-cycle write-to-read latency.
    popped.delete();
    m_ready = 1'b1;
    fork
      begin
        send(32'hAABBCCDD, 10);
        send(32'h11223344, 10);
        send(32'hDEADBEEF, 10);
      end
      begin
        @(negedge clk); chk("lat_first_write", 64'(bram_we), 64'd1);
        @(negedge clk); chk("lat_k0_m_valid", 64'(m_valid), 64'd0);
                        chk("lat_read_wins", 64'(s_ready), 64'd0);
        @(negedge clk); chk("lat_k1_m_valid", 64'(m_valid), 64'd0);
        @(negedge clk); chk("lat_k2_m_valid", 64'(m_valid), 64'd1);
                        chk("lat_k2_m_data", 64'(m_data), 64'hAABBCCDD);
      end
    join
    drain(30);
    chk("three_n", 64'(popped.size()), 64'd3);
    if (popped.size() == 3) begin
      chk("three_0", 64'(popped[0]), 64'hAABBCCDD);
      chk("three_1", 64'(popped[1]), 64'h11223344);
      chk("three_2", 64'(popped[2]), 64'hDEADBEEF);
    end

    // Fill with a stalled consumer: 6 words held, the rest refused.
    popped.delete();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(DW'(i), 10);
    s_valid = 1'b1;
    s_data  = 32'h6;
    repeat (8) begin
      @(negedge clk);
      chk("full_s_ready", 64'(s_ready), 64'd0);
      chk("full_count", 64'(count), 64'd6);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    send(32'h6, 20);
    send(32'h7, 20);
    drain(40);
    chk("fill_n", 64'(popped.size()), 64'd8);
    for (int i = 0; i < 8 && i < popped.size(); i++) chk("fill_order", 64'(popped[i]), 64'(i));

    // Continuous s_valid from empty: write, then one read-priority cycle.
    popped.delete();
    fork
      begin
        for (int i = 0; i < 16; i++) send(32'h100 + DW'(i), 10);
      end
      begin
        @(negedge clk); chk("cont_first_write", 64'(s_ready), 64'd1);
        @(negedge clk); chk("cont_read_cycle", 64'(s_ready), 64'd0);
                        chk("cont_read_no_we", 64'(bram_we), 64'd0);
        @(negedge clk); chk("cont_write_again", 64'(s_ready), 64'd1);
      end
    join
    drain(60);
    chk("cont_n", 64'(popped.size()), 64'd16);
    for (int i = 0; i < 16 && i < popped.size(); i++)
      chk("cont_order", 64'(popped[i]), 64'(32'h100 + i));

    // Random stream across pointer wrap.
    popped.delete();
    sent.delete();
    nsent = 0;
    repeat (600) begin
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      if (acc) begin
        sent.push_back(s_data);
        nsent++;
        s_valid = 1'b0;
      end
      if (!s_valid && nsent < 60 && $urandom_range(0, 3) != 0) begin
        s_valid = 1'b1;
        s_data  = $urandom;
      end
      m_ready = ($urandom_range(0, 2) != 0);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    drain(40);
    chk("rand_sent", 64'(nsent), 64'd60);
    chk("rand_n", 64'(popped.size()), 64'(sent.size()));
    for (int i = 0; i < sent.size() && i < popped.size(); i++)
      chk("rand_order", 64'(popped[i]), 64'(sent[i]));

    // Reset with words held: contents discarded at once.
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'hA0 + DW'(i), 10);
    repeat (3) @(posedge clk);
    #1;
    chk("prerst_m_valid", 64'(m_valid), 64'd1);
    chk("prerst_count", 64'(count), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("async_rst_m_valid", 64'(m_valid), 64'd0);
    chk("async_rst_count", 64'(count), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    popped.delete();
    m_ready = 1'b1;
    send(32'h55, 10);
    drain(20);
    chk("post_rst_n", 64'(popped.size()), 64'd1);
    if (popped.size() != 0) chk("post_rst_first", 64'(popped[0]), 64'h55);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
